// File: rtl/noc_inject_arbiter_pkg.sv
// rtl/noc_inject_arbiter_pkg.sv - shared NoC injection constants, flit field offsets and arbiter state encoding
package noc_inject_arbiter_pkg;

    localparam int NUM_VCS           = 2;
    localparam int FLIT_BUFFER_DEPTH = 8;
    localparam int FLIT_DATA_WIDTH   = 32;
    localparam int DEST_BITS         = 4;
    localparam int VC_BITS           = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
    localparam int FLIT_W            = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH;
    localparam int CNT_W             = $clog2(FLIT_BUFFER_DEPTH + 1);

    // Flit layout, MSB first: {valid, tail, dest, vc, data}
    localparam int FLIT_DATA_LSB  = 0;
    localparam int FLIT_VC_LSB    = FLIT_DATA_LSB + FLIT_DATA_WIDTH;
    localparam int FLIT_DEST_LSB  = FLIT_VC_LSB + VC_BITS;
    localparam int FLIT_TAIL_BIT  = FLIT_DEST_LSB + DEST_BITS;
    localparam int FLIT_VALID_BIT = FLIT_TAIL_BIT + 1;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// rtl/noc_inject_arbiter_if.sv - request bus from the local traffic sources to the injection arbiter
interface noc_inject_arbiter_if #(
    parameter int NUM_REQ         = 4,
    parameter int DEST_BITS       = 4,
    parameter int VC_BITS         = 1,
    parameter int FLIT_DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_tail;
    logic [NUM_REQ*DEST_BITS-1:0]       req_dest;
    logic [NUM_REQ*VC_BITS-1:0]         req_vc;
    logic [NUM_REQ*FLIT_DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_ready;

    modport master (
        output req_valid, req_tail, req_dest, req_vc, req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_tail, req_dest, req_vc, req_data,
        output req_ready
    );
endinterface

// File: rtl/noc_inject_arbiter_rr_arbiter.sv
// rtl/noc_inject_arbiter_rr_arbiter.sv - combinational round-robin picker
// Grants the first eligible index at or above ptr_i, wrapping past N-1.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     eligible_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o
);
    logic found;
    int   idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && eligible_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/noc_inject_arbiter.sv
// rtl/noc_inject_arbiter.sv - credit-aware round-robin NoC injection arbiter with wormhole lock
// Optional INJ_STATS_EN adds per-requester flit counters and a stall counter.
module noc_inject_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int NUM_VCS         = noc_inject_arbiter_pkg::NUM_VCS,
    parameter int VC_BITS         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    parameter int DEST_BITS       = noc_inject_arbiter_pkg::DEST_BITS,
    parameter int FLIT_DATA_WIDTH = noc_inject_arbiter_pkg::FLIT_DATA_WIDTH,
    parameter int BUF_DEPTH       = noc_inject_arbiter_pkg::FLIT_BUFFER_DEPTH,
    parameter int FLIT_W          = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH,
    parameter int CNT_W           = $clog2(BUF_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    noc_inject_arbiter_if.slave    req,
    output logic [FLIT_W-1:0]      flit_out,
    output logic                   sendFlit,
    input  logic [VC_BITS:0]       credit_in,
    output logic                   cred_err
`ifdef INJ_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]  stat_flits,
    output logic [31:0]            stat_stall
`endif
);
    import noc_inject_arbiter_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e                state_q, state_d;
    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]          owner_q, owner_d;
    logic [VC_BITS-1:0]        lock_vc_q, lock_vc_d;
    logic [CNT_W-1:0]          cnt_q [NUM_VCS];
    logic [CNT_W-1:0]          cnt_d [NUM_VCS];
    logic                      cred_err_q, cred_err_d;
    logic [FLIT_W-1:0]         flit_q, flit_d;
    logic                      send_q, send_d;

    logic [VC_BITS-1:0]         vc_of   [NUM_REQ];
    logic [DEST_BITS-1:0]       dest_of [NUM_REQ];
    logic [FLIT_DATA_WIDTH-1:0] data_of [NUM_REQ];
    logic [2**VC_BITS-1:0]      vc_ok;
    logic [NUM_REQ-1:0]         eligible, rr_grant, grant;
    logic [PTR_W-1:0]           win;
    logic                       xfer;
    logic [VC_BITS-1:0]         xfer_vc;
    logic [NUM_VCS-1:0]         dec_v, inc_v;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            vc_of[i]   = req.req_vc[i*VC_BITS +: VC_BITS];
            dest_of[i] = req.req_dest[i*DEST_BITS +: DEST_BITS];
            data_of[i] = req.req_data[i*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
        end
    end

    always_comb begin
        vc_ok = '0;
        for (int v = 0; v < NUM_VCS; v++) vc_ok[v] = (cnt_q[v] != '0);
    end

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++)
            eligible[i] = en && req.req_valid[i] && vc_ok[vc_of[i]];
    end

    rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .eligible_i (eligible),
        .ptr_i      (rr_ptr_q),
        .grant_o    (rr_grant)
    );

    // While locked only the owner may move, and only on the VC captured at its head flit.
    always_comb begin
        grant = '0;
        if (state_q == ST_ARB)
            grant = rr_grant;
        else if (en && req.req_valid[owner_q] && vc_ok[lock_vc_q])
            grant[owner_q] = 1'b1;
    end

    assign req.req_ready = grant;

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) win = PTR_W'(i);
    end

    assign xfer    = |grant;
    assign xfer_vc = (state_q == ST_ARB) ? vc_of[win] : lock_vc_q;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        lock_vc_d = lock_vc_q;
        if (xfer) begin
            rr_ptr_d = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
            if (state_q == ST_ARB) begin
                if (!req.req_tail[win]) begin
                    state_d   = ST_LOCKED;
                    owner_d   = win;
                    lock_vc_d = xfer_vc;
                end
            end else if (req.req_tail[win]) begin
                state_d = ST_ARB;
            end
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            dec_v[v] = xfer && (xfer_vc == VC_BITS'(v));
            inc_v[v] = credit_in[VC_BITS] && (credit_in[VC_BITS-1:0] == VC_BITS'(v));
        end
    end

    // A simultaneous grant and return on one VC cancel; a return into a full counter is an error.
    always_comb begin
        cred_err_d = cred_err_q;
        for (int v = 0; v < NUM_VCS; v++) begin
            cnt_d[v] = cnt_q[v];
            if (inc_v[v] && !dec_v[v]) begin
                if (cnt_q[v] == CNT_W'(BUF_DEPTH)) cred_err_d = 1'b1;
                else                               cnt_d[v]   = cnt_q[v] + CNT_W'(1);
            end else if (dec_v[v] && !inc_v[v]) begin
                cnt_d[v] = cnt_q[v] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        flit_d = '0;
        send_d = xfer;
        if (xfer)
            flit_d = {1'b1, req.req_tail[win], dest_of[win], xfer_vc, data_of[win]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ARB;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            lock_vc_q  <= '0;
            cred_err_q <= 1'b0;
            flit_q     <= '0;
            send_q     <= 1'b0;
            for (int v = 0; v < NUM_VCS; v++) cnt_q[v] <= CNT_W'(BUF_DEPTH);
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_vc_q  <= lock_vc_d;
            cred_err_q <= cred_err_d;
            flit_q     <= flit_d;
            send_q     <= send_d;
            for (int v = 0; v < NUM_VCS; v++) cnt_q[v] <= cnt_d[v];
        end
    end

    assign flit_out = flit_q;
    assign sendFlit = send_q;
    assign cred_err = cred_err_q;

`ifdef INJ_STATS_EN
    logic [31:0] stat_flits_q [NUM_REQ];
    logic [31:0] stat_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) stat_flits_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (grant[i]) stat_flits_q[i] <= stat_flits_q[i] + 32'd1;
            if ((|req.req_valid) && !xfer) stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) stat_flits[i*32 +: 32] = stat_flits_q[i];
    end

    assign stat_stall = stat_stall_q;
`endif
endmodule

// File: tb/tb_noc_inject_arbiter.sv
// tb/tb_noc_inject_arbiter.sv - self-checking bench for noc_inject_arbiter
module tb_noc_inject_arbiter;
    localparam int NR = 4;
    localparam int NV = 2;
    localparam int VB = 1;
    localparam int DB = 4;
    localparam int DW = 32;
    localparam int BD = 8;
    localparam int FW = 2 + DB + VB + DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [FW-1:0] flit_out;
    logic          sendFlit;
    logic [VB:0]   credit_in = '0;
    logic          cred_err;
`ifdef INJ_STATS_EN
    logic [NR*32-1:0] stat_flits;
    logic [31:0]      stat_stall;
`endif

    noc_inject_arbiter_if #(.NUM_REQ(NR), .DEST_BITS(DB), .VC_BITS(VB), .FLIT_DATA_WIDTH(DW)) bus ();

    noc_inject_arbiter #(
        .NUM_REQ(NR), .NUM_VCS(NV), .VC_BITS(VB), .DEST_BITS(DB),
        .FLIT_DATA_WIDTH(DW), .BUF_DEPTH(BD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (bus),
        .flit_out  (flit_out),
        .sendFlit  (sendFlit),
        .credit_in (credit_in),
        .cred_err  (cred_err)
`ifdef INJ_STATS_EN
        ,
        .stat_flits (stat_flits),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [NR-1:0] obs_rdy;

    // Reference model: credits per VC, rotating priority pointer, optional packet owner.
    int            m_cred [NV];
    int            m_ptr;
    bit            m_lock;
    int            m_owner;
    int            m_lvc;
    bit            m_err;
    logic [FW-1:0] m_flit;
    bit            m_send;
    int            m_sf [NR];
    int            m_stall;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int v = 0; v < NV; v++) m_cred[v] = BD;
        for (int i = 0; i < NR; i++) m_sf[i] = 0;
        m_ptr = 0; m_lock = 0; m_owner = 0; m_lvc = 0; m_err = 0;
        m_flit = '0; m_send = 0; m_stall = 0;
    endfunction

    function automatic int vc_in(int i);
        return int'(bus.req_vc[i*VB +: VB]);
    endfunction

    function automatic int m_pick();
        if (!en) return -1;
        if (m_lock) return (bus.req_valid[m_owner] && m_cred[m_lvc] > 0) ? m_owner : -1;
        for (int k = 0; k < NR; k++) begin
            int i = (m_ptr + k) % NR;
            if (bus.req_valid[i] && m_cred[vc_in(i)] > 0) return i;
        end
        return -1;
    endfunction

    function automatic void m_step();
        int w = m_pick();
        int v = -1;
        int cv = int'(credit_in[VB-1:0]);
        logic [VB-1:0] vcb;
        if (w >= 0) begin
            v = m_lock ? m_lvc : vc_in(w);
            vcb = VB'(v);
            m_flit = {1'b1, bus.req_tail[w], bus.req_dest[w*DB +: DB], vcb, bus.req_data[w*DW +: DW]};
            m_send = 1;
            m_cred[v]--;
            m_ptr = (w + 1) % NR;
            m_sf[w]++;
            if (m_lock) begin
                if (bus.req_tail[w]) m_lock = 0;
            end else if (!bus.req_tail[w]) begin
                m_lock = 1; m_owner = w; m_lvc = v;
            end
        end else begin
            m_flit = '0;
            m_send = 0;
            if (|bus.req_valid) m_stall++;
        end
        if (credit_in[VB]) begin
            if (w >= 0 && v == cv)     m_cred[cv]++;
            else if (m_cred[cv] == BD) m_err = 1;
            else                       m_cred[cv]++;
        end
    endfunction

    task automatic cyc();
        logic [NR-1:0] er;
        int w;
        @(negedge clk);
        er = '0;
        w = m_pick();
        if (w >= 0) er[w] = 1'b1;
        obs_rdy = bus.req_ready;
        chk("req_ready", obs_rdy, er);
        @(posedge clk);
        m_step();
        #1;
        chk("sendFlit", sendFlit, m_send);
        chk("flit_out", flit_out, m_flit);
        chk("cred_err", cred_err, m_err);
        for (int v = 0; v < NV; v++) chk("credit_cnt", dut.cnt_q[v], m_cred[v]);
    endtask

    task automatic drive(input bit e, input logic [NR-1:0] vl, input logic [NR-1:0] tl,
                         input logic [NR-1:0] vc, input logic [VB:0] cr);
        en = e;
        bus.req_valid = vl;
        bus.req_tail  = tl;
        bus.req_vc    = vc;
        credit_in     = cr;
    endtask

    typedef struct {
        bit            en;
        logic [NR-1:0] valid;
        logic [NR-1:0] tail;
        logic [NR-1:0] vc;
        logic [VB:0]   cred;
        logic [NR-1:0] exp_rdy;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 4'b0101, 4'b1111, 4'b0000, 2'b00, 4'b0001};
        tbl[1] = '{1'b1, 4'b0100, 4'b1111, 4'b0000, 2'b00, 4'b0100};
        tbl[2] = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 2'b00, 4'b0000};
        tbl[3] = '{1'b1, 4'b0010, 4'b0000, 4'b0000, 2'b00, 4'b0010};
        tbl[4] = '{1'b1, 4'b1010, 4'b0000, 4'b0000, 2'b00, 4'b0010};
        tbl[5] = '{1'b1, 4'b1010, 4'b0000, 4'b0000, 2'b00, 4'b0010};
        tbl[6] = '{1'b1, 4'b1010, 4'b0010, 4'b0000, 2'b00, 4'b0010};
        tbl[7] = '{1'b1, 4'b1000, 4'b1000, 4'b0000, 2'b00, 4'b1000};

        drive(0, '0, '0, '0, '0);
        bus.req_dest = {NR{4'h5}};
        bus.req_data = {NR{32'h0000beef}};
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sendFlit", sendFlit, 0);
        chk("rst_flit_out", flit_out, 0);
        chk("rst_cred_err", cred_err, 0);
        chk("rst_state", dut.state_q, noc_inject_arbiter_pkg::ST_ARB);
        for (int v = 0; v < NV; v++) chk("rst_cnt", dut.cnt_q[v], BD);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        for (int r = 0; r < 8; r++) begin
            drive(tbl[r].en, tbl[r].valid, tbl[r].tail, tbl[r].vc, tbl[r].cred);
            cyc();
            chk("tbl_ready", obs_rdy, tbl[r].exp_rdy);
            chk("tbl_send", sendFlit, |tbl[r].exp_rdy);
            if (r == 1) chk("tbl_cnt0_after_two", dut.cnt_q[0], 6);
        end

        drive(1, 4'b0001, 4'b0001, 4'b0000, 2'b10);
        cyc();
        chk("same_cycle_cnt0", dut.cnt_q[0], 1);
        for (int k = 0; k < 7; k++) begin
            drive(1, 4'b0000, 4'b0000, 4'b0000, 2'b10);
            cyc();
        end
        chk("refill_cnt0", dut.cnt_q[0], BD);
        chk("refill_no_err", cred_err, 0);
        cyc();
        drive(1, 4'b0000, 4'b0000, 4'b0000, 2'b00);
        cyc();
        cyc();
        chk("overflow_cnt0", dut.cnt_q[0], BD);
        chk("overflow_err_sticky", cred_err, 1);

        drive(1, 4'b0100, 4'b0000, 4'b0100, 2'b00);
        cyc();
        cyc();
        drive(0, 4'b0100, 4'b0000, 4'b0100, 2'b00);
        cyc();
        chk("en0_no_grant", obs_rdy, 0);
        chk("en0_still_locked", dut.state_q, noc_inject_arbiter_pkg::ST_LOCKED);
        drive(1, 4'b0100, 4'b0000, 4'b0000, 2'b00);
        cyc();
        chk("locked_vc_field", flit_out[DW +: VB], 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_flit", flit_out, 0);
        chk("async_rst_send", sendFlit, 0);
        chk("async_rst_err", cred_err, 0);
        m_reset();
        drive(0, '0, '0, '0, '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        chk("post_rst_state", dut.state_q, noc_inject_arbiter_pkg::ST_ARB);
        for (int v = 0; v < NV; v++) chk("post_rst_cnt", dut.cnt_q[v], BD);

        for (int k = 0; k < 8; k++) begin
            drive(1, 4'b0001, 4'b0001, 4'b0001, 2'b00);
            cyc();
            chk("vc1_burst_grant", obs_rdy, 4'b0001);
        end
        drive(1, 4'b0001, 4'b0001, 4'b0001, 2'b11);
        cyc();
        chk("vc1_empty_stall", obs_rdy, 4'b0000);
        chk("vc1_one_credit", dut.cnt_q[1], 1);
        drive(1, 4'b0001, 4'b0001, 4'b0001, 2'b00);
        cyc();
        chk("vc1_ninth_grant", obs_rdy, 4'b0001);
        drive(1, 4'b0000, 4'b0000, 4'b0000, 2'b00);
        cyc();
`ifdef INJ_STATS_EN
        chk("stat_flits0", stat_flits[31:0], 9);
        chk("stat_stall", stat_stall, 1);
`endif

        for (int k = 0; k < 3000; k++) begin
            en = ($urandom_range(0, 9) != 0);
            bus.req_valid = NR'($urandom);
            bus.req_tail  = NR'($urandom) & NR'($urandom);
            bus.req_vc    = (NR*VB)'($urandom);
            bus.req_dest  = (NR*DB)'($urandom);
            for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = $urandom;
            credit_in = {($urandom_range(0, 2) == 0), VB'($urandom)};
            cyc();
        end
`ifdef INJ_STATS_EN
        for (int i = 0; i < NR; i++) chk("rand_stat_flits", stat_flits[i*32 +: 32], m_sf[i]);
        chk("rand_stat_stall", stat_stall, m_stall);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/noc_inject_arbiter.md
Name: noc_inject_arbiter

Overview:
Shares one NoC injection port between NUM_REQ local traffic sources inside a PE. It keeps per-VC credit counters, arbitrates round-robin among requesters whose VC has credit, and holds a wormhole lock from head flit to tail flit. It formats each flit as {valid, tail, dest, vc, data}, registers it onto flit_out, and absorbs credit returns from the router.

Parameters:
NUM_REQ, 4, number of requesters
NUM_VCS, 2, virtual channels
VC_BITS, 1, max(1, clog2(NUM_VCS))
DEST_BITS, 4, destination field width (clog2 of user recv ports)
FLIT_DATA_WIDTH, 32, payload width
BUF_DEPTH, 8, router input buffer depth per VC, which is also the initial credit
FLIT_W, 2+DEST_BITS+VC_BITS+FLIT_DATA_WIDTH, flit port width
CNT_W, clog2(BUF_DEPTH+1), credit counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  grant enable; credits are still accepted while low
req_valid  in  NUM_REQ  requester i has a flit
req_tail  in  NUM_REQ  flit is the last of its packet
req_dest  in  NUM_REQ*DEST_BITS  destination per requester
req_vc  in  NUM_REQ*VC_BITS  VC per requester; sampled only on the head flit
req_data  in  NUM_REQ*FLIT_DATA_WIDTH  payload per requester
req_ready  out  NUM_REQ  one-hot grant (combinational)
flit_out  out  FLIT_W  registered flit
sendFlit  out  1  flit_out valid strobe
credit_in  in  1+VC_BITS  {valid, vc} credit return
cred_err  out  1  sticky credit-overflow flag

Behaviour:
- Reset, asynchronous: flit_out=0, sendFlit=0, cred_err=0, all credit counters=BUF_DEPTH, rr_ptr=0, state=ARB, lock_owner=0, lock_vc=0.
- Transfer: a flit from requester i transfers at the clock edge where req_valid[i] and req_ready[i] are both high.
- req_ready is a function of registered state and the current request inputs only. It has no dependence on flit_out.
- Output latency: flit_out and sendFlit are valid on the cycle after the transfer.
  - When no transfer occurred on the previous edge, flit_out=0 and sendFlit=0 (one-cycle pulse per flit).
- State ARB:
  - Eligible requester i: en && req_valid[i] && cnt[req_vc[i]]>0.
  - Grant goes to the first eligible requester at or after rr_ptr, searching upward with wrap.
  - On transfer: rr_ptr = winner+1 mod NUM_REQ.
  - If req_tail=0 on that transfer, go to LOCKED with lock_owner=winner and lock_vc=req_vc[winner].
  - A single-flit packet (tail=1) stays in ARB.
- State LOCKED:
  - Only lock_owner may be granted, and only when en && req_valid && cnt[lock_vc]>0.
  - The flit VC field is lock_vc; req_vc is ignored.
  - If the owner deasserts valid, or credit is 0, the output bubbles and the lock is held.
  - A transfer with tail=1 returns the state to ARB. rr_ptr is already past the owner.
- Credits:
  - A transfer on VC v decrements cnt[v].
  - A credit_in with valid=1 for VC v increments cnt[v].
  - Both on the same VC in the same cycle: cnt[v] is unchanged.
  - An increment while cnt[v]==BUF_DEPTH with no simultaneous decrement holds the counter at BUF_DEPTH and sets cred_err. cred_err clears only on reset.
  - Underflow cannot occur, because a grant requires cnt>0.
- Flit format: flit_out = {1'b1, tail, dest, vc, data}, the same field order as the PE traffic generators.
- Reset mid-packet clears the lock. The requester must restart its packet from the head flit.
- en=0 while LOCKED: the lock is held and no grant is issued.

Optional Feature:
INJ_STATS_EN
- When defined:
  - Adds output stat_flits (NUM_REQ*32): per-requester count of transferred flits.
  - Adds output stat_stall (32): cycles in which some req_valid was high but no transfer occurred.
  - Both counters wrap at 2^32 and are cleared by reset.
- When undefined: these ports and registers do not exist.

Decomposition:
- Shared package/include: flit field offsets (valid, tail, dest, vc, data), FLIT_W/CNT_W derivation, and ARB/LOCKED state encodings.
  - These live in connect_parameters.v alongside NUM_VCS, FLIT_BUFFER_DEPTH and FLIT_DATA_WIDTH.
- One sub-module: rr_arbiter.
  - Parameter N.
  - Inputs: eligible vector, pointer.
  - Output: one-hot grant.
  - Purely combinational.

Test Plan:
1. Reset, then requesters 0 and 2 each hold a single-flit packet (VC0, dest 5, data 'hbeef) → grants go 0 then 2 on consecutive cycles; sendFlit pulses one cycle after each grant; cnt[0]=6.
2. Requester 1 sends 4 flits (tail on the 4th) while requester 3 also requests → requester 3 gets no grant until the cycle after requester 1's tail transfer; the 4 flits appear on flit_out uninterrupted.
3. Nine single-flit sends on VC1 with no credit returns → 8 flits leave; the 9th stalls with cnt[1]=0. One credit_in {1,1} → the 9th flit is granted on the next cycle.
4. A transfer and a credit_in for VC0 in the same cycle → cnt[0] is unchanged. A credit_in while cnt[0]=8 → cnt[0] stays 8 and cred_err=1 persists until reset.
5. Assert rst_n low mid-packet, while LOCKED on requester 2 → flit_out=0 and sendFlit=0 immediately; after release, state=ARB and all counters=8.
6. With INJ_STATS_EN defined, run scenario 3 → stat_flits[0]=9 and stat_stall=1 (the stall lasts one cycle before the credit returns).
